// File: rtl/truth_table_sweep_ctrl.sv
// Exhaustive truth-table sweep sequencer.
// Steps through every input vector of an N_IN-input combinational block in
// ascending order, holds each one for HOLD_CYC cycles, samples the block's
// output on the last cycle of each window and compares it with the golden
// table EXPECTED. Reports the mismatch count, the first failing vector and a
// pass/done status. All outputs come straight from registers.
module truth_table_sweep_ctrl #(
    parameter int unsigned               N_IN     = 4,
    parameter int unsigned               HOLD_CYC = 20,
    parameter logic [(2**N_IN)-1:0]      EXPECTED = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic              f_in,
    output logic [N_IN-1:0]   vec_out,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [N_IN:0]     err_count,
    output logic              fail_valid,
    output logic [N_IN-1:0]   first_fail
);

    // A hold counter of at least one bit keeps HOLD_CYC=1 legal; it then stays 0.
    localparam int unsigned     CW       = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
    localparam logic [CW-1:0]   CNT_LAST = CW'(HOLD_CYC - 1);
    localparam logic [CW-1:0]   CNT_ONE  = CW'(1);
    localparam logic [N_IN-1:0] VEC_LAST = '1;
    localparam logic [N_IN-1:0] VEC_ONE  = N_IN'(1);
    localparam logic [N_IN:0]   ERR_ONE  = (N_IN + 1)'(1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_FINISH = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [N_IN-1:0]   vec_q, vec_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [N_IN:0]     err_q, err_d;
    logic              fv_q, fv_d;
    logic [N_IN-1:0]   ff_q, ff_d;
    logic              pass_q, pass_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              miss_s;

    // Golden-table lookup: true when the sampled output disagrees with the table.
    function automatic logic is_mismatch(input logic [N_IN-1:0] v, input logic f);
        return (f != EXPECTED[v]);
    endfunction

    // Next-state and next-output logic for the sweep FSM.
    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        fv_d    = fv_q;
        ff_d    = ff_q;
        pass_d  = pass_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        miss_s  = 1'b0;

        case (state_q)
            S_IDLE: begin
                vec_d = '0;
                cnt_d = '0;
                // start takes priority over abort here: abort has no meaning in IDLE.
                if (start) begin
                    state_d = S_RUN;
                    busy_d  = 1'b1;
                    err_d   = '0;
                    fv_d    = 1'b0;
                    ff_d    = '0;
                    pass_d  = 1'b0;
                end else begin
                    state_d = S_IDLE;
                end
            end

            S_RUN: begin
                if (abort) begin
                    // Abort beats a coinciding final compare; partial error info is kept.
                    state_d = S_IDLE;
                    vec_d   = '0;
                    cnt_d   = '0;
                    pass_d  = 1'b0;
                end else begin
                    busy_d = 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        miss_s = is_mismatch(vec_q, f_in);
                        if (miss_s) begin
                            err_d = err_q + ERR_ONE;
                            if (!fv_q) begin
                                fv_d = 1'b1;
                                ff_d = vec_q;
                            end else begin
                                fv_d = fv_q;
                            end
                        end else begin
                            err_d = err_q;
                        end
                        cnt_d = '0;
                        if (vec_q == VEC_LAST) begin
                            state_d = S_FINISH;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                            vec_d   = '0;
                            pass_d  = (err_d == '0);
                        end else begin
                            vec_d = vec_q + VEC_ONE;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
            end

            S_FINISH: begin
                // One-cycle done pulse; start arriving here is deliberately dropped.
                state_d = S_IDLE;
                vec_d   = '0;
                cnt_d   = '0;
            end

            default: begin
                state_d = S_IDLE;
                vec_d   = '0;
                cnt_d   = '0;
            end
        endcase
    end

    // State and output registers with immediate asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            vec_q   <= '0;
            cnt_q   <= '0;
            err_q   <= '0;
            fv_q    <= 1'b0;
            ff_q    <= '0;
            pass_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            fv_q    <= fv_d;
            ff_q    <= ff_d;
            pass_q  <= pass_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign vec_out    = vec_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign pass       = pass_q;
    assign err_count  = err_q;
    assign fail_valid = fv_q;
    assign first_fail = ff_q;

endmodule

// File: tb/tb_truth_table_sweep_ctrl.sv
// Bench for truth_table_sweep_ctrl: three sequencers (hold 2 with the true
// table, hold 2 with two table bits inverted, hold 1 with the inverted table)
// each drive a model of f = A&B | C&~D whose output can be corrupted per
// vector by a flip mask. Expected results come from a table of records and
// from a per-vector reference count for randomized masks.
module tb_truth_table_sweep_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       start_w [3];
    logic       abort_w [3];
    logic       f_w     [3];
    logic [3:0] vec_w   [3];
    logic       busy_w  [3];
    logic       done_w  [3];
    logic       pass_w  [3];
    logic [4:0] err_w   [3];
    logic       fv_w    [3];
    logic [3:0] ff_w    [3];
    logic [15:0] mask_r [3];

    int checks = 0;
    int errors = 0;

    // Function under check: vec[3]=A ... vec[0]=D.
    function automatic logic golden(input logic [3:0] v);
        return (v[3] & v[2]) | (v[1] & ~v[0]);
    endfunction

    function automatic logic [15:0] make_tbl();
        logic [15:0] t;
        for (int v = 0; v < 16; v++) t[v] = golden(4'(v));
        return t;
    endfunction

    localparam logic [15:0] TBL   = make_tbl();
    localparam logic [15:0] EXP_B = TBL ^ 16'h1020;
    localparam logic [15:0] EXP_C = ~TBL;

    assign f_w[0] = golden(vec_w[0]) ^ mask_r[0][vec_w[0]];
    assign f_w[1] = golden(vec_w[1]) ^ mask_r[1][vec_w[1]];
    assign f_w[2] = golden(vec_w[2]) ^ mask_r[2][vec_w[2]];

    truth_table_sweep_ctrl #(.N_IN(4), .HOLD_CYC(2), .EXPECTED(TBL)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_w[0]), .abort(abort_w[0]), .f_in(f_w[0]),
        .vec_out(vec_w[0]), .busy(busy_w[0]), .done(done_w[0]), .pass(pass_w[0]),
        .err_count(err_w[0]), .fail_valid(fv_w[0]), .first_fail(ff_w[0]));

    truth_table_sweep_ctrl #(.N_IN(4), .HOLD_CYC(2), .EXPECTED(EXP_B)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_w[1]), .abort(abort_w[1]), .f_in(f_w[1]),
        .vec_out(vec_w[1]), .busy(busy_w[1]), .done(done_w[1]), .pass(pass_w[1]),
        .err_count(err_w[1]), .fail_valid(fv_w[1]), .first_fail(ff_w[1]));

    truth_table_sweep_ctrl #(.N_IN(4), .HOLD_CYC(1), .EXPECTED(EXP_C)) u_dut_c (
        .clk(clk), .rst_n(rst_n), .start(start_w[2]), .abort(abort_w[2]), .f_in(f_w[2]),
        .vec_out(vec_w[2]), .busy(busy_w[2]), .done(done_w[2]), .pass(pass_w[2]),
        .err_count(err_w[2]), .fail_valid(fv_w[2]), .first_fail(ff_w[2]));

    typedef struct {
        int          sel;
        logic [15:0] mask;
        int          err;
        int          fv;
        int          ff;
        int          pass;
        int          lat;
    } rec_t;

    rec_t tbl[8];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [15:0] exp_of(input int sel);
        case (sel)
            0:       return TBL;
            1:       return EXP_B;
            default: return EXP_C;
        endcase
    endfunction

    // Reference: count vectors whose produced output differs from the golden table.
    task automatic model(input int sel, input logic [15:0] mask, output int e, output int ff);
        logic [15:0] ex;
        ex = exp_of(sel);
        e  = 0;
        ff = 0;
        for (int v = 0; v < 16; v++) begin
            if ((golden(4'(v)) ^ mask[v]) != ex[v]) begin
                if (e == 0) ff = v;
                e++;
            end
        end
    endtask

    // Full sweep with optional start re-pulses; checks sequence, done pulse and final status.
    task automatic run_check(input rec_t r, input int restart_k, input bit fin_restart,
                             input bit abort_at_start, input string tag);
        int hold;
        int lat;
        int dc;
        bit seq_ok;
        hold = (r.sel == 2) ? 1 : 2;
        mask_r[r.sel] = r.mask;
        lat = -1;
        dc = 0;
        seq_ok = 1'b1;
        @(posedge clk); #1;
        start_w[r.sel] = 1'b1;
        abort_w[r.sel] = abort_at_start;
        for (int k = 0; k <= 16 * hold + 3; k++) begin
            @(posedge clk); #1;
            abort_w[r.sel] = 1'b0;
            start_w[r.sel] = (k == restart_k) || (fin_restart && (k == 16 * hold));
            if (done_w[r.sel]) begin
                dc++;
                if (lat < 0) lat = k;
            end
            if (k < 16 * hold) begin
                if (vec_w[r.sel] != 4'(k / hold) || !busy_w[r.sel]) seq_ok = 1'b0;
            end else begin
                if (vec_w[r.sel] != 4'd0 || busy_w[r.sel]) seq_ok = 1'b0;
            end
        end
        chk({tag, " seq"},       int'(seq_ok),        1);
        chk({tag, " done_cnt"},  dc,                  1);
        chk({tag, " latency"},   lat,                 r.lat);
        chk({tag, " err_count"}, int'(err_w[r.sel]),  r.err);
        chk({tag, " fail_vld"},  int'(fv_w[r.sel]),   r.fv);
        chk({tag, " first_fl"},  int'(ff_w[r.sel]),   r.ff);
        chk({tag, " pass"},      int'(pass_w[r.sel]), r.pass);
    endtask

    // Start a sweep on DUT a, then assert abort so it is sampled at edge abort_k+1.
    task automatic abort_at(input logic [15:0] mask, input int abort_k, input int exp_err,
                            input int exp_fv, input int exp_ff, input string tag);
        int dc;
        mask_r[0] = mask;
        @(posedge clk); #1;
        start_w[0] = 1'b1;
        @(posedge clk); #1;
        start_w[0] = 1'b0;
        for (int k = 1; k <= abort_k; k++) begin
            @(posedge clk); #1;
        end
        abort_w[0] = 1'b1;
        @(posedge clk); #1;
        abort_w[0] = 1'b0;
        chk({tag, " busy"},      int'(busy_w[0]), 0);
        chk({tag, " vec"},       int'(vec_w[0]),  0);
        chk({tag, " pass"},      int'(pass_w[0]), 0);
        chk({tag, " err_count"}, int'(err_w[0]),  exp_err);
        chk({tag, " fail_vld"},  int'(fv_w[0]),   exp_fv);
        chk({tag, " first_fl"},  int'(ff_w[0]),   exp_ff);
        dc = int'(done_w[0]);
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (done_w[0] || busy_w[0]) dc++;
        end
        chk({tag, " no_done"}, dc, 0);
    endtask

    initial begin
        int e;
        int ff;
        rec_t r;

        tbl[0] = '{0, 16'h0000,  0, 0,  0, 1, 32};
        tbl[1] = '{1, 16'h0000,  2, 1,  5, 0, 32};
        tbl[2] = '{2, 16'h0000, 16, 1,  0, 0, 16};
        tbl[3] = '{0, 16'h0100,  1, 1,  8, 0, 32};
        tbl[4] = '{0, 16'h8000,  1, 1, 15, 0, 32};
        tbl[5] = '{2, 16'hFFFF,  0, 0,  0, 1, 16};
        tbl[6] = '{1, 16'h1020,  0, 0,  0, 1, 32};
        tbl[7] = '{0, 16'hFFFF, 16, 1,  0, 0, 32};

        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            start_w[i] = 1'b0;
            abort_w[i] = 1'b0;
            mask_r[i]  = 16'h0000;
        end
        #12;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rst%0d vec", i),  int'(vec_w[i]),  0);
            chk($sformatf("rst%0d busy", i), int'(busy_w[i]), 0);
            chk($sformatf("rst%0d done", i), int'(done_w[i]), 0);
            chk($sformatf("rst%0d pass", i), int'(pass_w[i]), 0);
            chk($sformatf("rst%0d err", i),  int'(err_w[i]),  0);
            chk($sformatf("rst%0d fv", i),   int'(fv_w[i]),   0);
            chk($sformatf("rst%0d ff", i),   int'(ff_w[i]),   0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        // Table-driven sweeps.
        for (int i = 0; i < 8; i++) begin
            run_check(tbl[i], -1, 1'b0, 1'b0, $sformatf("tbl%0d", i));
        end

        // start re-pulsed at vector 3 and inside FINISH must be ignored.
        run_check(tbl[0], 6, 1'b1, 1'b0, "restart");

        // abort in IDLE is ignored: status from the previous sweep stays.
        mask_r[0] = 16'h0000;
        @(posedge clk); #1;
        abort_w[0] = 1'b1;
        @(posedge clk); #1;
        abort_w[0] = 1'b0;
        chk("idle_abort busy", int'(busy_w[0]), 0);
        chk("idle_abort pass", int'(pass_w[0]), 1);

        // abort while vector 7 is driven; vector 3 failed earlier.
        abort_at(16'h0008, 14, 1, 1, 3, "abort7");
        // abort coinciding with the final compare of vector 15: no compare, no done.
        abort_at(16'h8000, 31, 0, 0, 0, "abort_last");
        // start and abort together in IDLE: start accepted, full clean sweep.
        run_check(tbl[0], -1, 1'b0, 1'b1, "start_abort");

        // Asynchronous reset mid-cycle at vector 9.
        mask_r[0] = 16'h0004;
        @(posedge clk); #1;
        start_w[0] = 1'b1;
        @(posedge clk); #1;
        start_w[0] = 1'b0;
        for (int k = 1; k <= 18; k++) begin
            @(posedge clk); #1;
        end
        chk("pre_rst vec", int'(vec_w[0]), 9);
        chk("pre_rst err", int'(err_w[0]), 1);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async vec",  int'(vec_w[0]),  0);
        chk("async busy", int'(busy_w[0]), 0);
        chk("async err",  int'(err_w[0]),  0);
        chk("async fv",   int'(fv_w[0]),   0);
        chk("async ff",   int'(ff_w[0]),   0);
        @(negedge clk);
        rst_n = 1'b1;
        run_check(tbl[0], -1, 1'b0, 1'b0, "post_rst");

        // Randomized flip masks against the reference count.
        for (int n = 0; n < 6; n++) begin
            r.sel  = int'($urandom_range(2, 0));
            r.mask = 16'($urandom);
            model(r.sel, r.mask, e, ff);
            r.err  = e;
            r.fv   = (e != 0) ? 1 : 0;
            r.ff   = ff;
            r.pass = (e == 0) ? 1 : 0;
            r.lat  = (r.sel == 2) ? 16 : 32;
            run_check(r, -1, 1'b0, 1'b0, $sformatf("rnd%0d", n));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
